remote_cmd_sched: RTL
=====================

Name: remote_cmd_sched

Overview:
- Sequencer and arbiter in front of the RemoteComm UART command link.
- Two requesters (e.g. test script and manual/console path) compete for the link; round-robin arbitration.
- Winning 16-bit command is issued via snd_cmd/cmd, then the block waits for cmd_snt and an 8-bit response.
- Response 0xA5 = ack (done), 0x5A = nack (retry). Silence past TIMEOUT also retries. Error reported after RETRIES failed retries.

Parameters:
- TIMEOUT, 50000, clocks allowed from snd_cmd to ack before a retry (minimum 4).
- RETRIES, 3, retries after the first attempt; total attempts = RETRIES+1 (0..15).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req0  in  1  requester 0 wants to send cmd0 (level)
- cmd0  in  16  requester 0 command
- req1  in  1  requester 1 wants to send cmd1 (level)
- cmd1  in  16  requester 1 command
- gnt0, gnt1  out  1 each  one-cycle grant pulse; cmdN captured this cycle, requester may drop reqN
- done0, done1  out  1 each  one-cycle pulse: command acked
- err0, err1  out  1 each  one-cycle pulse: retries exhausted
- busy  out  1  high whenever state != IDLE
- snd_cmd  out  1  one-cycle pulse to RemoteComm
- cmd  out  16  command to RemoteComm
- cmd_snt  in  1  RemoteComm level flag: both bytes transmitted
- resp_rdy  in  1  RemoteComm response valid
- resp  in  8  RemoteComm response byte

Behaviour:
- Reset: all outputs 0, cmd = 16'h0000, state IDLE, rr pointer = 0 (requester 0 favoured), timer = 0, retry count = 0.
- All outputs are registered; no combinational path from input to output.
- State IDLE:
  - Arbitration, sampled each cycle:
    - only req0 → requester 0; only req1 → requester 1.
    - both → the requester indicated by the rr pointer.
  - On the next edge, together:
    - gntN <= 1
    - cmd <= cmdN
    - snd_cmd <= 1
    - owner <= N
    - retry count <= 0; timer <= 0
    - rr pointer <= other requester
    - state → WAIT_SNT
  - Latency: req sampled at cycle k → gnt and snd_cmd high in cycle k+1.
- cmd is held constant from issue until the block returns to IDLE. RemoteComm reads the high byte live, so cmd must not change mid-transfer.
- State WAIT_SNT: timer increments each cycle. When cmd_snt = 1, go to WAIT_RESP; the timer is not cleared.
  - cmd_snt is ignored in the cycle snd_cmd is high and the cycle after, because a stale flag from the previous command is still set there.
- State WAIT_RESP: timer keeps incrementing.
- Response handling, in WAIT_SNT or WAIT_RESP:
  - resp_rdy with resp == 8'hA5 (ack): doneOWNER pulses next cycle; → IDLE.
  - resp_rdy with resp == 8'h5A (nack): treated as a failure.
  - resp_rdy with any other value: ignored.
- Failure = nack, or timer == TIMEOUT-1 with no ack.
  - If retry count < RETRIES: retry count +1, timer <= 0, snd_cmd pulses again with the same cmd, → WAIT_SNT.
  - Otherwise: errOWNER pulses, → IDLE.
- Simultaneous events:
  - Ack and timeout in the same cycle: ack wins.
  - Nack and timeout in the same cycle: counted as one failure.
- Requests while busy: not granted and not queued; reqN is re-evaluated in IDLE.
- IDLE lasts at least one cycle between commands, so at most one grant occurs per command lifetime.
- Fairness: with both reqs held high, grants alternate 0,1,0,1…
- Widths and wrap:
  - Timer width = $clog2(TIMEOUT); it never wraps, because it is cleared on every snd_cmd.
  - Retry counter is 4 bits.
- Reset mid-operation: immediate return to IDLE, all pulses cleared, no done/err reported for the aborted command.

Test Plan (TIMEOUT=20, RETRIES=2, RemoteComm behavioural model):
- req0 with cmd0=16'h1234, model returns 0xA5 after cmd_snt → gnt0 in cycle k+1, snd_cmd one pulse with cmd=16'h1234, done0 one pulse, busy low after; no err0.
- req0 and req1 both held high, cmd0=16'hAAAA, cmd1=16'hBBBB, always ack → cmd order on link AAAA, BBBB, AAAA, BBBB; gnt pulses alternate starting with gnt0.
- Model answers 0x5A, then 0x5A, then 0xA5 → exactly 3 snd_cmd pulses with identical cmd, done pulses once, no err.
- Model never responds → snd_cmd pulses at 20-cycle intervals, 3 total; errN pulses 20 cycles after the third; state IDLE.
- Model sends 0x33 then 0xA5 → 0x33 ignored, single done, no retry.
- rst_n asserted in WAIT_RESP → all outputs 0 immediately; after release, pending req1 is granted normally.

Source files
------------

// File: rtl/remote_cmd_sched.sv
// remote_cmd_sched: round-robin arbiter between two requesters and a retrying
// command sequencer in front of the RemoteComm UART link.
module remote_cmd_sched #(
    parameter int TIMEOUT = 50000,
    parameter int RETRIES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic [15:0] cmd0,
    input  logic        req1,
    input  logic [15:0] cmd1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic        err0,
    output logic        err1,
    output logic        busy,
    output logic        snd_cmd,
    output logic [15:0] cmd,
    input  logic        cmd_snt,
    input  logic        resp_rdy,
    input  logic [7:0]  resp
);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_SNT  = 2'd1;
    localparam logic [1:0] WAIT_RESP = 2'd2;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [3:0]    R_MAX  = 4'(RETRIES);

    logic [1:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [15:0]   cmd_q, cmd_d;
    logic [1:0]    gnt_q, gnt_d, done_q, done_d, err_q, err_d;
    logic          owner_q, owner_d, rr_q, rr_d;
    logic          snd_q, snd_d, blank_q, blank_d, busy_q, busy_d;
    logic          pick, ack, fail;

    always_comb begin
        pick    = (req0 && req1) ? rr_q : req1;
        ack     = resp_rdy && (resp == 8'hA5);
        fail    = !ack && ((resp_rdy && (resp == 8'h5A)) || (timer_q == T_LAST));
        state_d = state_q;
        timer_d = timer_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        gnt_d   = 2'b00;
        done_d  = 2'b00;
        err_d   = 2'b00;
        snd_d   = 1'b0;
        // cmd_snt still shows the previous command during the issue cycle and the one after
        blank_d = snd_q;
        if (state_q == IDLE) begin
            if (req0 || req1) begin
                gnt_d[pick] = 1'b1;
                cmd_d       = pick ? cmd1 : cmd0;
                snd_d       = 1'b1;
                owner_d     = pick;
                cnt_d       = 4'd0;
                timer_d     = '0;
                rr_d        = !pick;
                state_d     = WAIT_SNT;
            end
        end else begin
            timer_d = timer_q + TW'(1);
            if (state_q == WAIT_SNT && cmd_snt && !snd_q && !blank_q)
                state_d = WAIT_RESP;
            if (ack) begin
                done_d[owner_q] = 1'b1;
                state_d         = IDLE;
            end else if (fail) begin
                if (cnt_q < R_MAX) begin
                    cnt_d   = cnt_q + 4'd1;
                    timer_d = '0;
                    snd_d   = 1'b1;
                    state_d = WAIT_SNT;
                end else begin
                    err_d[owner_q] = 1'b1;
                    state_d        = IDLE;
                end
            end
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            cnt_q   <= 4'd0;
            cmd_q   <= 16'h0000;
            owner_q <= 1'b0;
            rr_q    <= 1'b0;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            err_q   <= 2'b00;
            snd_q   <= 1'b0;
            blank_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            snd_q   <= snd_d;
            blank_q <= blank_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt0    = gnt_q[0];
    assign gnt1    = gnt_q[1];
    assign done0   = done_q[0];
    assign done1   = done_q[1];
    assign err0    = err_q[0];
    assign err1    = err_q[1];
    assign busy    = busy_q;
    assign snd_cmd = snd_q;
    assign cmd     = cmd_q;
endmodule
